// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a single subtract cell and a borrow register
// walk the operands LSB first, producing (a - b) mod 2^WIDTH and the final borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [WIDTH-1:0] dSr_q;
    logic [WIDTH-1:0] dSr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             borrow_d;
    logic             diffBit;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrowOut_q;

    // Subtract cell for the current bit pair; the new result bit enters at the MSB.
    always_comb begin
        diffBit  = aSr_q[0] ^ bSr_q[0] ^ borrow_q;
        borrow_d = (~aSr_q[0] & bSr_q[0]) | (~(aSr_q[0] ^ bSr_q[0]) & borrow_q);
        dSr_d    = (dSr_q >> 1) | (WIDTH'(diffBit) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aSr_q       <= '0;
            bSr_q       <= '0;
            dSr_q       <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diff_q      <= '0;
            borrowOut_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        aSr_q    <= a;
                        bSr_q    <= b;
                        dSr_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    aSr_q    <= aSr_q >> 1;
                    bSr_q    <= bSr_q >> 1;
                    dSr_q    <= dSr_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Results are captured from the last bit's next-state so they are valid with done.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        diff_q      <= dSr_d;
                        borrowOut_q <= borrow_d;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrowOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 8-bit and 1-bit instances checked
// every cycle against a transaction-level model plus directed literal vectors.
module tb_serial_subtractor;
    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: an accepted op keeps busy for WIDTH+1 cycles, the last of which is done.
    int         m8Timer = 0;
    logic [7:0] m8Pend, m8Diff;
    logic       m8PendB, m8Borrow;
    int         m1Timer = 0;
    logic [0:0] m1Pend, m1Diff;
    logic       m1PendB, m1Borrow;

    always @(posedge clk) begin
        if (rst) begin
            m8Timer  <= 0;
            m8Diff   <= '0;
            m8Borrow <= 1'b0;
        end else if (m8Timer == 0) begin
            if (start8) begin
                m8Timer <= 9;
                m8Pend  <= a8 - b8;
                m8PendB <= (a8 < b8);
            end
        end else begin
            m8Timer <= m8Timer - 1;
            if (m8Timer == 2) begin
                m8Diff   <= m8Pend;
                m8Borrow <= m8PendB;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1Timer  <= 0;
            m1Diff   <= '0;
            m1Borrow <= 1'b0;
        end else if (m1Timer == 0) begin
            if (start1) begin
                m1Timer <= 2;
                m1Pend  <= a1 - b1;
                m1PendB <= (a1 < b1);
            end
        end else begin
            m1Timer <= m1Timer - 1;
            if (m1Timer == 2) begin
                m1Diff   <= m1Pend;
                m1Borrow <= m1PendB;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model busy8",   32'(busy8),   32'(m8Timer != 0));
            checkOutput("model done8",   32'(done8),   32'(m8Timer == 1));
            checkOutput("model diff8",   32'(diff8),   32'(m8Diff));
            checkOutput("model borrow8", 32'(borrow8), 32'(m8Borrow));
            checkOutput("model busy1",   32'(busy1),   32'(m1Timer != 0));
            checkOutput("model done1",   32'(done1),   32'(m1Timer == 1));
            checkOutput("model diff1",   32'(diff1),   32'(m1Diff));
            checkOutput("model borrow1", 32'(borrow1), 32'(m1Borrow));
        end
    end

    // Launches one op from a negedge, counts edges to done, checks literal results; ends in IDLE.
    task automatic applyStimulus(input bit useNarrow, input logic [7:0] aIn, input logic [7:0] bIn,
                                 input logic [7:0] expDiff, input logic expBorrow,
                                 input int expEdges, input string name);
        int edges;
        if (useNarrow) begin
            start1 = 1'b1; a1 = aIn[0]; b1 = bIn[0];
        end else begin
            start8 = 1'b1; a8 = aIn; b8 = bIn;
        end
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        while (!(useNarrow ? done1 : done8) && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput({name, " latency"}, 32'(edges), 32'(expEdges));
        checkOutput({name, " diff"},   useNarrow ? 32'(diff1) : 32'(diff8), 32'(expDiff));
        checkOutput({name, " borrow"}, useNarrow ? 32'(borrow1) : 32'(borrow8), 32'(expBorrow));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] full;
        logic [7:0] ra, rb;
        int doneCount;
        int lastDone;

        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEn = 1;
        checkOutput("reset busy",   32'(busy8),   32'd0);
        checkOutput("reset done",   32'(done8),   32'd0);
        checkOutput("reset diff",   32'(diff8),   32'd0);
        checkOutput("reset borrow", 32'(borrow8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 8'h5A, 8'h23, 8'h37, 1'b0, 9, "5A-23");
        applyStimulus(0, 8'h00, 8'h01, 8'hFF, 1'b1, 9, "00-01");
        applyStimulus(0, 8'h80, 8'h80, 8'h00, 1'b0, 9, "80-80");
        applyStimulus(0, 8'hC3, 8'h00, 8'hC3, 1'b0, 9, "C3-00");
        applyStimulus(0, 8'h00, 8'hFF, 8'h01, 1'b1, 9, "00-FF");
        applyStimulus(0, 8'hFF, 8'h00, 8'hFF, 1'b0, 9, "FF-00");

        // Start held high: accepts land on edges 0,10,20,30; operands are garbage elsewhere.
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        doneCount = 0;
        lastDone  = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                doneCount++;
                checkOutput("held start diff", 32'(diff8), 32'h0F);
                if (lastDone >= 0) checkOutput("held start period", 32'(c - lastDone), 32'd10);
                lastDone = c;
            end
            if ((c + 1) % 10 == 0) begin
                a8 = 8'h10; b8 = 8'h01;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        checkOutput("held start done count", 32'(doneCount), 32'd4);
        @(negedge clk);

        // Abort on the 4th RUN cycle.
        start8 = 1'b1; a8 = 8'h9C; b8 = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("abort busy before", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy",   32'(busy8),   32'd0);
        checkOutput("abort done",   32'(done8),   32'd0);
        checkOutput("abort diff",   32'(diff8),   32'd0);
        checkOutput("abort borrow", 32'(borrow8), 32'd0);
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abort no done", 32'(done8), 32'd0);
        end

        applyStimulus(1, 8'h00, 8'h00, 8'h00, 1'b0, 2, "w1 0-0");
        applyStimulus(1, 8'h00, 8'h01, 8'h01, 1'b1, 2, "w1 0-1");
        applyStimulus(1, 8'h01, 8'h00, 8'h01, 1'b0, 2, "w1 1-0");
        applyStimulus(1, 8'h01, 8'h01, 8'h00, 1'b0, 2, "w1 1-1");

        for (int i = 0; i < 2500; i++) begin
            ra = 8'($urandom);
            rb = (i % 7 == 0) ? ra : 8'($urandom);
            full = {1'b0, ra} - {1'b0, rb};
            applyStimulus(0, ra, rb, full[7:0], full[8], 9, "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
